// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: decides advance / hold / bubble for IF/ID and
// ID/EXE to cover load-use stalls, multi-cycle MUL occupancy and branch flushes.
`ifndef ASIZE
`define ASIZE 5
`endif

module pipe_hazard_ctrl #(
    parameter int         ASIZE      = `ASIZE,
    parameter logic [5:0] OP_LOAD    = 6'h23,
    parameter logic [5:0] OP_MUL     = 6'h18,
    parameter int         MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [ASIZE-1:0] id_rs,
    input  logic [ASIZE-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [ASIZE-1:0] id_dest,
    input  logic             id_wen,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idexe_en,
    output logic             idexe_bubble,
    output logic             exe_busy,
    output logic [1:0]       hz_state,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MUL_WAIT = 2'b01
    } hz_state_e;

    // Wide enough for MUL_CYCLES-1 up to 15.
    localparam int            CW        = 5;
    localparam logic [CW-1:0] MUL_LOAD  = CW'(MUL_CYCLES - 1);
    localparam bit            MUL_MULTI = (MUL_CYCLES > 1);

    hz_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ex_valid_q, ex_valid_d;
    logic             ex_load_q, ex_load_d;
    logic             ex_wen_q, ex_wen_d;
    logic [ASIZE-1:0] ex_dest_q, ex_dest_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic src_hit;
    logic lu;
    logic issue;

    assign src_hit = (id_rs_used && (id_rs == ex_dest_q)) ||
                     (id_rt_used && (id_rt == ex_dest_q));

    // Register 0 is hard-wired, so a load targeting it never blocks a reader.
    assign lu = ex_valid_q && ex_load_q && ex_wen_q && (ex_dest_q != '0) &&
                id_valid && src_hit;

    // Normal issue slot: running, no redirect, no load-use stall.
    assign issue = rst && (state_q == ST_RUN) && !br_taken && !lu;

    // NOTE: every output gets a default before the priority chain; a path that
    // leaves a combinational variable unassigned would infer a latch.
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idexe_en     = 1'b0;
        idexe_bubble = 1'b0;
        exe_busy     = 1'b0;
        if (!rst) begin
            ifid_flush   = 1'b1;
            idexe_en     = 1'b1;
            idexe_bubble = 1'b1;
        end else if (state_q == ST_MUL_WAIT) begin
            exe_busy = 1'b1;
        end else if (br_taken) begin
            pc_en        = 1'b1;
            ifid_en      = 1'b1;
            ifid_flush   = 1'b1;
            idexe_en     = 1'b1;
            idexe_bubble = 1'b1;
        end else if (lu) begin
            idexe_en     = 1'b1;
            idexe_bubble = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idexe_en = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_valid_d  = ex_valid_q;
        ex_load_d   = ex_load_q;
        ex_wen_d    = ex_wen_q;
        ex_dest_d   = ex_dest_q;
        stall_cnt_d = stall_cnt_q;

        // Bubble wins over capture; neither means ID/EXE holds.
        if (idexe_bubble) begin
            ex_valid_d = 1'b0;
        end else if (idexe_en) begin
            ex_valid_d = id_valid;
            ex_load_d  = (id_op == OP_LOAD);
            ex_wen_d   = id_wen;
            ex_dest_d  = id_dest;
        end

        case (state_q)
            ST_RUN: begin
                if (issue && id_valid && (id_op == OP_MUL) && MUL_MULTI) begin
                    state_d = ST_MUL_WAIT;
                    cnt_d   = MUL_LOAD;
                end
            end
            ST_MUL_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: shadow payload is qualified by ex_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        ex_load_q <= ex_load_d;
        ex_wen_q  <= ex_wen_d;
        ex_dest_q <= ex_dest_d;
    end

    assign hz_state  = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of per-cycle vectors with a
// scoreboard queue, plus a saturation run on a MUL_CYCLES=16 instance.
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] OP_LOAD = 6'h23;
    localparam logic [5:0] OP_MUL  = 6'h18;
    localparam logic [5:0] OP_ALU  = 6'h00;

    // Output vector bit order: pc_en ifid_en ifid_flush idexe_en idexe_bubble exe_busy hz_state[1:0]
    localparam logic [7:0] E_RUN = 8'b1101_0000, M_RUN = 8'b1111_1111;
    localparam logic [7:0] E_LU  = 8'b0000_1000, M_LU  = 8'b1110_1111;
    localparam logic [7:0] E_BR  = 8'b1010_1000, M_BR  = 8'b1010_1111;
    localparam logic [7:0] E_MW  = 8'b0000_0101, M_MW  = 8'b1111_1111;
    localparam logic [7:0] E_RST = 8'b0011_1000, M_RST = 8'b1111_1100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, id_rs_used, id_rt_used, id_wen, br_taken;
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        pc_en, ifid_en, ifid_flush, idexe_en, idexe_bubble, exe_busy;
    logic [1:0]  hz_state;
    logic [15:0] stall_cnt;

    logic        s_rst, s_id_valid, s_rs_used, s_rt_used, s_wen, s_br;
    logic [5:0]  s_op;
    logic [4:0]  s_rs, s_rt, s_dest;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idexe_en, s_idexe_bubble, s_exe_busy;
    logic [1:0]  s_hz_state;
    logic [15:0] s_stall_cnt;

    pipe_hazard_ctrl #(.MUL_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dest(id_dest), .id_wen(id_wen), .br_taken(br_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idexe_en(idexe_en),
        .idexe_bubble(idexe_bubble), .exe_busy(exe_busy), .hz_state(hz_state),
        .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MUL_CYCLES(16)) dut_sat (
        .clk(clk), .rst(s_rst), .id_valid(s_id_valid), .id_op(s_op),
        .id_rs(s_rs), .id_rt(s_rt), .id_rs_used(s_rs_used), .id_rt_used(s_rt_used),
        .id_dest(s_dest), .id_wen(s_wen), .br_taken(s_br),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idexe_en(s_idexe_en),
        .idexe_bubble(s_idexe_bubble), .exe_busy(s_exe_busy), .hz_state(s_hz_state),
        .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic       r, v;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       rsu, rtu;
        logic [4:0] dest;
        logic       wen, br;
        logic [7:0] exp, mask;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0]  exp, mask;
        logic [15:0] stall;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic r, logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                logic rsu, logic rtu, logic [4:0] dest, logic wen, logic br,
                                logic [7:0] exp, logic [7:0] mask, string name);
        vec_t t;
        t.r = r; t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu;
        t.dest = dest; t.wen = wen; t.br = br; t.exp = exp; t.mask = mask; t.name = name;
        return t;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_stall;
        logic [7:0]  act;
        exp_t        e;

        rst = 1'b0; id_valid = 1'b0; id_op = OP_ALU; id_rs = '0; id_rt = '0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_dest = '0; id_wen = 1'b0; br_taken = 1'b0;
        s_rst = 1'b0; s_id_valid = 1'b1; s_op = OP_MUL; s_rs = '0; s_rt = '0;
        s_rs_used = 1'b0; s_rt_used = 1'b0; s_dest = 5'd1; s_wen = 1'b1; s_br = 1'b0;

        //                r  v  op       rs rt  rsu rtu dest wen br  exp    mask   name
        vecs.push_back(mk(0, 0, OP_ALU,  0, 0,  0,  0,  0,  0,  0, E_RST, M_RST, "rst_0"));
        vecs.push_back(mk(0, 0, OP_ALU,  0, 0,  0,  0,  0,  0,  0, E_RST, M_RST, "rst_1"));
        vecs.push_back(mk(1, 0, OP_ALU,  0, 0,  0,  0,  0,  0,  0, E_RUN, M_RUN, "idle_after_rst"));
        vecs.push_back(mk(1, 1, OP_LOAD, 1, 0,  1,  0,  5,  1,  0, E_RUN, M_RUN, "load_r5"));
        vecs.push_back(mk(1, 1, OP_ALU,  5, 2,  1,  1,  6,  1,  0, E_LU,  M_LU,  "lu_stall_rs"));
        vecs.push_back(mk(1, 1, OP_ALU,  5, 2,  1,  1,  6,  1,  0, E_RUN, M_RUN, "lu_release_rs"));
        vecs.push_back(mk(1, 1, OP_LOAD, 2, 0,  1,  0,  0,  1,  0, E_RUN, M_RUN, "load_r0"));
        vecs.push_back(mk(1, 1, OP_ALU,  0, 0,  1,  1,  8,  1,  0, E_RUN, M_RUN, "r0_no_hazard"));
        vecs.push_back(mk(1, 1, OP_LOAD, 1, 0,  1,  0,  7,  1,  0, E_RUN, M_RUN, "load_r7"));
        vecs.push_back(mk(1, 1, OP_ALU,  3, 7,  1,  0,  8,  1,  0, E_RUN, M_RUN, "rt_unused_no_hazard"));
        vecs.push_back(mk(1, 1, OP_LOAD, 1, 0,  1,  0, 11,  0,  0, E_RUN, M_RUN, "load_nowen"));
        vecs.push_back(mk(1, 1, OP_ALU, 11, 0,  1,  0, 12,  1,  0, E_RUN, M_RUN, "nowen_no_hazard"));
        vecs.push_back(mk(1, 1, OP_ALU,  1, 0,  1,  0, 13,  1,  0, E_RUN, M_RUN, "alu_r13"));
        vecs.push_back(mk(1, 1, OP_ALU, 13, 0,  1,  0, 14,  1,  0, E_RUN, M_RUN, "alu_alu_forwarded"));
        vecs.push_back(mk(1, 1, OP_LOAD, 1, 0,  1,  0,  9,  1,  0, E_RUN, M_RUN, "load_r9"));
        vecs.push_back(mk(1, 1, OP_ALU,  1, 9,  0,  1, 10,  1,  1, E_BR,  M_BR,  "branch_over_lu"));
        vecs.push_back(mk(1, 1, OP_LOAD, 1, 0,  1,  0,  9,  1,  0, E_RUN, M_RUN, "load_r9_again"));
        vecs.push_back(mk(1, 1, OP_ALU,  1, 9,  0,  1, 10,  1,  0, E_LU,  M_LU,  "lu_stall_rt"));
        vecs.push_back(mk(1, 1, OP_ALU,  1, 9,  0,  1, 10,  1,  0, E_RUN, M_RUN, "lu_release_rt"));
        vecs.push_back(mk(1, 1, OP_MUL,  1, 2,  1,  1,  3,  1,  0, E_RUN, M_RUN, "mul_issue"));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 1, OP_ALU, 3, 0, 1, 0, 4, 1, 0, E_MW, M_MW, "mul_wait"));
        vecs.push_back(mk(1, 1, OP_ALU,  3, 0,  1,  0,  4,  1,  0, E_RUN, M_RUN, "mul_done"));
        vecs.push_back(mk(1, 1, OP_MUL,  1, 2,  1,  1,  3,  1,  1, E_BR,  M_BR,  "mul_flushed"));
        vecs.push_back(mk(1, 0, OP_ALU,  0, 0,  0,  0,  0,  0,  0, E_RUN, M_RUN, "no_wait_after_flush"));
        vecs.push_back(mk(1, 1, OP_LOAD, 1, 0,  1,  0,  4,  1,  0, E_RUN, M_RUN, "load_r4"));
        vecs.push_back(mk(1, 1, OP_MUL,  4, 0,  1,  0,  3,  1,  0, E_LU,  M_LU,  "mul_lu_stall"));
        vecs.push_back(mk(1, 1, OP_MUL,  4, 0,  1,  0,  3,  1,  0, E_RUN, M_RUN, "mul_lu_issue"));
        vecs.push_back(mk(1, 1, OP_ALU,  3, 0,  1,  0,  5,  1,  1, E_MW,  M_MW,  "mw_ignores_br"));
        vecs.push_back(mk(1, 1, OP_ALU,  3, 0,  1,  0,  5,  1,  0, E_MW,  M_MW,  "mul_lu_wait"));
        vecs.push_back(mk(1, 1, OP_ALU,  3, 0,  1,  0,  5,  1,  0, E_MW,  M_MW,  "mul_lu_wait"));
        vecs.push_back(mk(1, 0, OP_ALU,  0, 0,  0,  0,  0,  0,  0, E_RUN, M_RUN, "mul_lu_done"));
        vecs.push_back(mk(1, 1, OP_MUL,  1, 2,  1,  1,  3,  1,  0, E_RUN, M_RUN, "mul_issue_2"));
        vecs.push_back(mk(1, 1, OP_ALU,  3, 0,  1,  0,  4,  1,  0, E_MW,  M_MW,  "mw_before_rst"));
        vecs.push_back(mk(0, 1, OP_ALU,  3, 0,  1,  0,  4,  1,  0, E_RST, M_RST, "rst_mid_mul"));
        vecs.push_back(mk(1, 0, OP_ALU,  0, 0,  0,  0,  0,  0,  0, E_RUN, M_RUN, "run_after_rst"));

        exp_stall = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst = vecs[i].r; id_valid = vecs[i].v; id_op = vecs[i].op;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rs_used = vecs[i].rsu;
            id_rt_used = vecs[i].rtu; id_dest = vecs[i].dest; id_wen = vecs[i].wen;
            br_taken = vecs[i].br;
            sb.push_back('{exp: vecs[i].exp, mask: vecs[i].mask, stall: exp_stall,
                           name: $sformatf("%0d_%s", i, vecs[i].name)});
            // Reference stall count: cleared by reset, +1 per stalled non-reset cycle.
            if (!vecs[i].r)
                exp_stall = '0;
            else if (!vecs[i].exp[7] && exp_stall != 16'hFFFF)
                exp_stall = exp_stall + 16'd1;
            @(negedge clk);
            e   = sb.pop_front();
            act = {pc_en, ifid_en, ifid_flush, idexe_en, idexe_bubble, exe_busy, hz_state};
            check({e.name, "/outs"}, {8'h00, act & e.mask}, {8'h00, e.exp & e.mask});
            check({e.name, "/stall_cnt"}, stall_cnt, e.stall);
        end

        // Saturation: back-to-back MULs, 15 stall cycles per 16-cycle period.
        @(negedge clk);
        s_rst = 1'b1;
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("sat_first_period", s_stall_cnt, 16'd15);
        check("sat_first_state", {14'd0, s_hz_state}, 16'd0);
        repeat (16 * 4367) @(posedge clk);
        @(negedge clk);
        check("sat_before_limit", s_stall_cnt, 16'hFFF0);
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("sat_hold", s_stall_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
